// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared widths, FSM encoding and constants for divider_8x8
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int N     = 8;
  localparam int CNT_W = $clog2(N);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
  localparam logic [N-1:0]     SAT_VAL   = {N{1'b1}};
  localparam logic [N-1:0]     NEG_Q_LIM = N'(1 << (N - 1));

  typedef logic [2:0] state_t;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_LOAD  = 3'd1;
  localparam logic [2:0] C_SHIFT = 3'd2;
  localparam logic [2:0] C_TRY   = 3'd3;
  localparam logic [2:0] C_FIX   = 3'd4;
  localparam logic [2:0] C_DONE  = 3'd5;

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
    return {N{1'b0}} - v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider_8x8_if.sv
// ============================================================================
// divider_8x8_if : operand/result bundle between the divider and its host
// Revision: 1.0
// ============================================================================
`default_nettype none

interface divider_8x8_if;
  import div_pkg::*;

  logic           Run;
  logic [2*N-1:0] Dividend;
  logic [N-1:0]   SW;
  logic [N-1:0]   Quotient;
  logic [N-1:0]   Remainder;
  logic           Done;
  logic           Overflow;
  logic           DivByZero;
  logic [6:0]     HEX0;
  logic [6:0]     HEX1;
  logic [6:0]     HEX2;
  logic [6:0]     HEX3;

  modport master (
    output Run, Dividend, SW,
    input  Quotient, Remainder, Done, Overflow, DivByZero, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  Run, Dividend, SW,
    output Quotient, Remainder, Done, Overflow, DivByZero, HEX0, HEX1, HEX2, HEX3
  );

endinterface

`default_nettype wire

// File: rtl/HexDriver.sv
// ============================================================================
// HexDriver : nibble to active-low 7-segment pattern (segment g is bit 6)
// Revision: 1.0
// ============================================================================
`default_nettype none

module HexDriver (
  input  logic [3:0] In0,
  output logic [6:0] Out0
);

  always_comb begin
    Out0 = 7'b1111111;
    case (In0)
      4'h0: Out0 = 7'b1000000;
      4'h1: Out0 = 7'b1111001;
      4'h2: Out0 = 7'b0100100;
      4'h3: Out0 = 7'b0110000;
      4'h4: Out0 = 7'b0011001;
      4'h5: Out0 = 7'b0010010;
      4'h6: Out0 = 7'b0000010;
      4'h7: Out0 = 7'b1111000;
      4'h8: Out0 = 7'b0000000;
      4'h9: Out0 = 7'b0010000;
      4'hA: Out0 = 7'b0001000;
      4'hB: Out0 = 7'b0000011;
      4'hC: Out0 = 7'b1000110;
      4'hD: Out0 = 7'b0100001;
      4'hE: Out0 = 7'b0000110;
      4'hF: Out0 = 7'b0001110;
      default: Out0 = 7'b1111111;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/subtracter_9.sv
// ============================================================================
// subtracter_9 : 9-bit difference S = A - B (two's complement wrap)
// Revision: 1.0
// ============================================================================
`default_nettype none

module subtracter_9 (
  input  logic [8:0] A,
  input  logic [8:0] B,
  output logic [8:0] S
);

  assign S = A - B;

endmodule

`default_nettype wire

// File: rtl/divider_8x8.sv
// ============================================================================
// divider_8x8 : sequential restoring 16/8 divider, one shift + one trial
// subtract per quotient bit. Define SIGNED_DIV_EN for two's-complement mode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module divider_8x8 (
  input  logic         Clk,
  input  logic         Reset_Load_Clear,
  divider_8x8_if.slave bus
);
  import div_pkg::*;

  state_t             r_state;
  logic [N-1:0]       r_d;
  logic [N:0]         r_r;
  logic [N-1:0]       r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_dbz;
  logic [N:0]         w_t;
  logic [2*N-1:0]     w_mag_n;
  logic [N-1:0]       w_mag_d;
  logic [4*4-1:0]     w_digits;
  logic [6:0]         w_seg [4];

  subtracter_9 u_sub (
    .A (r_r),
    .B ({1'b0, r_d}),
    .S (w_t)
  );

`ifdef SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_mag_n = bus.Dividend[2*N-1] ? ({(2*N){1'b0}} - bus.Dividend) : bus.Dividend;
  assign w_mag_d = bus.SW[N-1] ? neg_n(bus.SW) : bus.SW;

  always_ff @(posedge Clk) begin
    if (!Reset_Load_Clear) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == C_LOAD) begin
      r_neg_q <= bus.Dividend[2*N-1] ^ bus.SW[N-1];
      r_neg_r <= bus.Dividend[2*N-1];
    end
  end
`else
  assign w_mag_n = bus.Dividend;
  assign w_mag_d = bus.SW;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_Load_Clear) begin
      r_state <= C_IDLE;
      r_d     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: if (bus.Run) r_state <= C_LOAD;
        C_LOAD: begin
          r_d   <= w_mag_d;
          r_cnt <= '0;
          r_ovf <= 1'b0;
          r_dbz <= 1'b0;
          if (w_mag_d == '0) begin
            r_dbz   <= 1'b1;
            r_q     <= SAT_VAL;
            r_r     <= {1'b0, bus.Dividend[N-1:0]};
            r_state <= C_DONE;
          end else if (w_mag_n[2*N-1:N] >= w_mag_d) begin
            r_ovf   <= 1'b1;
            r_q     <= SAT_VAL;
            r_r     <= {1'b0, bus.Dividend[N-1:0]};
            r_state <= C_DONE;
          end else begin
            r_r     <= {1'b0, w_mag_n[2*N-1:N]};
            r_q     <= w_mag_n[N-1:0];
            r_state <= C_SHIFT;
          end
        end
        C_SHIFT: begin
          // R < D on entry, so dropping R[N] loses nothing
          {r_r, r_q} <= {r_r[N-1:0], r_q, 1'b0};
          r_state    <= C_TRY;
        end
        C_TRY: begin
          if (!w_t[N]) begin
            r_r    <= w_t;
            r_q[0] <= 1'b1;
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
`ifdef SIGNED_DIV_EN
            r_state <= C_FIX;
`else
            r_state <= C_DONE;
`endif
          end else begin
            r_state <= C_SHIFT;
          end
        end
`ifdef SIGNED_DIV_EN
        C_FIX: begin
          // Negative results may reach -128; positive ones stop at 127
          if (r_neg_q) begin
            if (r_q > NEG_Q_LIM) begin
              r_ovf <= 1'b1;
              r_q   <= SAT_VAL;
            end else begin
              r_q <= neg_n(r_q);
            end
          end else if (r_q[N-1]) begin
            r_ovf <= 1'b1;
            r_q   <= SAT_VAL;
          end
          if (r_neg_r) r_r <= {1'b0, neg_n(r_r[N-1:0])};
          r_state <= C_DONE;
        end
`endif
        C_DONE: if (!bus.Run) r_state <= C_IDLE;
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign bus.Quotient  = r_q;
  assign bus.Remainder = r_r[N-1:0];
  assign bus.Done      = (r_state == C_DONE);
  assign bus.Overflow  = r_ovf;
  assign bus.DivByZero = r_dbz;

  assign w_digits = {r_r[N-1:0], r_q};

  for (genvar i = 0; i < 4; i++) begin : g_hex
    HexDriver u_hex (
      .In0  (w_digits[4*i +: 4]),
      .Out0 (w_seg[i])
    );
  end

  assign bus.HEX0 = w_seg[0];
  assign bus.HEX1 = w_seg[1];
  assign bus.HEX2 = w_seg[2];
  assign bus.HEX3 = w_seg[3];

endmodule

`default_nettype wire

// File: tb/tb_divider_8x8.sv
// ============================================================================
// tb_divider_8x8 : scoreboard bench for divider_8x8
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_divider_8x8;
  import div_pkg::*;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dbz;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  divider_8x8_if bus();

  divider_8x8 dut (
    .Clk              (clk),
    .Reset_Load_Clear (rst_n),
    .bus              (bus)
  );

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dsr);
    exp_t e;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.q   = 8'hFF;
    e.r   = dvd[7:0];
    e.lat = 2;
`ifdef SIGNED_DIV_EN
    begin
      int sn, sd, mn, md, qi, ri;
      sn = int'($signed(dvd));
      sd = int'($signed(dsr));
      mn = (sn < 0) ? -sn : sn;
      md = (sd < 0) ? -sd : sd;
      if (md == 0) e.dbz = 1'b1;
      else if ((mn / 256) >= md) e.ovf = 1'b1;
      else begin
        qi = sn / sd;
        ri = sn % sd;
        e.lat = 19;
        e.r   = 8'(ri);
        if (qi > 127 || qi < -128) e.ovf = 1'b1;
        else e.q = 8'(qi);
      end
    end
`else
    if (dsr == 8'h00) e.dbz = 1'b1;
    else if (dvd[15:8] >= dsr) e.ovf = 1'b1;
    else begin
      e.q   = 8'(int'(dvd) / int'(dsr));
      e.r   = 8'(int'(dvd) % int'(dsr));
      e.lat = 18;
    end
`endif
    return e;
  endfunction

  // Starts one operation, scrambles operands mid-run, and scores the result
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dsr, input bit hold);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    bus.Dividend = dvd;
    bus.SW       = dsr;
    bus.Run      = 1'b1;
    sb.push_back(model(dvd, dsr));
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.Done) seen = 1'b1;
      else if (cyc == 3) begin
        bus.Dividend = 16'($urandom);
        bus.SW       = 8'($urandom);
        if (!hold) bus.Run = 1'b0;
      end
    end
    e = sb.pop_front();
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout %h/%h: Done never rose in %0d cycles", dvd, dsr, cyc);
    end
    n_tests++;
    if (cyc !== e.lat) begin
      n_fail++;
      $display("FAIL latency %h/%h: got %0d want %0d", dvd, dsr, cyc, e.lat);
    end
    n_tests++;
    if (bus.Quotient !== e.q) begin
      n_fail++;
      $display("FAIL quotient %h/%h: got %h want %h", dvd, dsr, bus.Quotient, e.q);
    end
    n_tests++;
    if (bus.Remainder !== e.r) begin
      n_fail++;
      $display("FAIL remainder %h/%h: got %h want %h", dvd, dsr, bus.Remainder, e.r);
    end
    n_tests++;
    if (bus.Overflow !== e.ovf || bus.DivByZero !== e.dbz) begin
      n_fail++;
      $display("FAIL flags %h/%h: got ovf=%b dbz=%b want ovf=%b dbz=%b",
               dvd, dsr, bus.Overflow, bus.DivByZero, e.ovf, e.dbz);
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.Run = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_release: got Done=%b want 0", bus.Done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.Quotient !== 8'h00 || bus.Remainder !== 8'h00 || bus.Done !== 1'b0 ||
        bus.Overflow !== 1'b0 || bus.DivByZero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%h r=%h done=%b ovf=%b dbz=%b want all 0",
               bus.Quotient, bus.Remainder, bus.Done, bus.Overflow, bus.DivByZero);
    end
    n_tests++;
    if (bus.HEX0 !== seg(4'h0) || bus.HEX3 !== seg(4'h0)) begin
      n_fail++;
      $display("FAIL reset_hex: got %h %h want %h", bus.HEX3, bus.HEX0, seg(4'h0));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(16'h0064, 8'h07, 1'b0);
    finish_op();
  endtask

  task automatic test_hex();
    run_op(16'h1234, 8'h56, 1'b1);
    n_tests++;
    if (bus.HEX3 !== seg(4'h1) || bus.HEX2 !== seg(4'h0) ||
        bus.HEX1 !== seg(4'h3) || bus.HEX0 !== seg(4'h6)) begin
      n_fail++;
      $display("FAIL hex_1036: got %h %h %h %h want %h %h %h %h",
               bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0,
               seg(4'h1), seg(4'h0), seg(4'h3), seg(4'h6));
    end
    finish_op();
  endtask

  task automatic test_overflow();
    run_op(16'h0900, 8'h08, 1'b1);
    finish_op();
  endtask

  task automatic test_div_by_zero();
    int bad;
    run_op(16'hABCD, 8'h00, 1'b1);
    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.Done !== 1'b1 || bus.Quotient !== 8'hFF) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL done_hold: got %0d bad cycles want 0", bad);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    bus.Dividend = 16'h1234;
    bus.SW       = 8'h56;
    bus.Run      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    bus.Run = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.Quotient !== 8'h00 || bus.Remainder !== 8'h00 || bus.Done !== 1'b0 ||
        bus.Overflow !== 1'b0 || bus.DivByZero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got q=%h r=%h done=%b want all 0",
               bus.Quotient, bus.Remainder, bus.Done);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.Done !== 1'b0 || bus.Quotient !== 8'h00) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %0d bad cycles want 0", bad);
    end
    run_op(16'h0064, 8'h07, 1'b0);
    finish_op();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  d;
      logic [15:0] n;
      d = 8'($urandom_range(1, 255));
      n = {8'($urandom_range(0, int'(d) - 1)), 8'($urandom)};
      if (i == 7) n = 16'hFFFF;
      run_op(n, d, 1'($urandom_range(0, 1)));
      finish_op();
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    run_op(16'hFF9C, 8'h07, 1'b1);
    finish_op();
    run_op(16'h0064, 8'hF9, 1'b0);
    finish_op();
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    bus.Run      = 1'b0;
    bus.Dividend = '0;
    bus.SW       = '0;
    test_reset();
    test_basic();
    test_hex();
    test_overflow();
    test_div_by_zero();
    test_reset_mid();
    test_back_to_back();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/divider_8x8.md
Name: divider_8x8

Overview:
Sequential unsigned restoring divider, the inverse of the lab shift-add multiplier.
- Divides a 16-bit dividend (typically a multiplier product {Aval,Bval}) by an 8-bit divisor taken from SW.
- Produces an 8-bit quotient and an 8-bit remainder using one shift step and one trial-subtract step per quotient bit.
- Results go to HEX0-HEX3 through HexDriver; working registers are exported for LED/debug display.

Parameters:
N, 8, divisor/quotient/remainder width; dividend is 2N; iteration count = N; hex display shows the low 16 bits of {R,Q}

Ports:
Clk  input  1  system clock, all state on rising edge
Reset_Load_Clear  input  1  synchronous, active-low reset; clears all state
Run  input  1  level start request (active-high, debounced upstream)
Dividend  input  2N  dividend, sampled in LOAD
SW  input  N  divisor, sampled in LOAD
Quotient  output  N  quotient register (live during compute, final in DONE)
Remainder  output  N  partial/final remainder register
Done  output  1  high only in DONE state
Overflow  output  1  quotient would exceed N bits; held until next LOAD/reset
DivByZero  output  1  divisor was 0; held until next LOAD/reset
HEX0..HEX3  output  7 each  {Remainder,Quotient} nibbles, HEX0 = Quotient[3:0] ... HEX3 = Remainder[7:4]

Behaviour:
- Reset (Reset_Load_Clear==0 at an edge): state=IDLE; Quotient, Remainder, the 9-bit working remainder R, Done, Overflow and DivByZero all go to 0; iteration counter=0. Reset wins over every other event, including mid-computation.
- Working registers:
  - R is N+1 bits (the extra bit is the MSB guard, as X in the multiplier); Q is N bits.
  - Remainder = R[N-1:0]; Quotient = Q.
- IDLE: Run==1 -> LOAD; otherwise stay.
- LOAD (1 cycle): latch D=SW; R={1'b0,Dividend[2N-1:N]}; Q=Dividend[N-1:0]; clear both flags; cnt=0.
  - D==0: DivByZero=1, Q=all-ones, R={0,Dividend[N-1:0]}, next=DONE.
  - Otherwise, Dividend[2N-1:N] >= D: Overflow=1, Q=all-ones, R={0,Dividend[N-1:0]}, next=DONE.
  - Otherwise next=SHIFT.
- SHIFT: {R,Q} <= {R[N-1:0],Q,1'b0} (left shift by one); next=TRY.
- TRY:
  - T = R - {1'b0,D}, computed by subtracter_9.
  - T[N]==0 (non-negative): R=T, Q[0]=1. Else R and Q are unchanged.
  - cnt++. If cnt reaches N-1 before the increment, next=DONE; else next=SHIFT.
  - Invariant: R < {0,D} on entry to SHIFT, so the 9-bit R never overflows.
- DONE: Done=1; outputs held stable. Run==0 -> IDLE. While Run stays high, remain in DONE, so one Run press gives exactly one operation.
- Latency from the Run edge sampled in IDLE to Done high:
  - Normal: 1 (LOAD) + 2N (16) + 1 = Done visible on cycle 18.
  - Overflow / divide-by-zero: Done visible on cycle 2.
- SW and Dividend changes after LOAD have no effect on the running operation.
- Run dropping mid-computation has no effect; the operation completes.
- HEX outputs are combinational from the Quotient/Remainder registers.

Optional Feature:
SIGNED_DIV_EN
- Defined: two's-complement division, quotient truncates toward zero, remainder takes the dividend's sign.
  - LOAD stores sign flags and magnitudes of Dividend and SW.
  - Overflow check on magnitudes as above.
  - An extra FIX state between the final TRY and DONE negates Q and/or R per the sign flags (+1 cycle latency, Done on cycle 19).
  - Overflow also set in FIX if the magnitude quotient exceeds 127 with a positive result, or exceeds 128 with a negative result.
- Undefined: unsigned only, no FIX state, latency as above.

Decomposition:
- Package div_pkg: state enum (IDLE, LOAD, SHIFT, TRY, FIX, DONE), localparam for the iteration count width, and the saturation value constant.
- Sub-modules:
  - Reuse the existing subtracter_9 for the trial subtract.
  - Reuse HexDriver x4 for the displays.
  - No new sub-module is needed.

Test Plan:
- Dividend=16'h0064, SW=8'h07, Run pulse -> Done on cycle 18, Quotient=8'h0E, Remainder=8'h02, flags 0.
- Dividend=16'h1234, SW=8'h56 -> Quotient=8'h36, Remainder=8'h10; HEX3..0 display "1036".
- Dividend=16'h0900, SW=8'h08 -> Overflow=1, Quotient=8'hFF, Remainder=8'h00, Done on cycle 2.
- SW=8'h00, any Dividend -> DivByZero=1, Quotient=8'hFF; Run held high for 50 cycles -> stays in DONE, no restart; Run low -> IDLE.
- Reset_Load_Clear low during the 5th SHIFT -> next cycle all outputs 0 and state IDLE; a new Run then computes a correct result.
- (SIGNED_DIV_EN) Dividend=16'hFF9C (-100), SW=8'h07 -> Quotient=8'hF2 (-14), Remainder=8'hFE (-2), Done on cycle 19.
